vga_sync_gen: RTL

//   Raster timing source for the 800x480 display path. Free-running h/v pixel counters drive
//   vga_h/vga_v into vga_frame. hsync/vsync/display-enable are delayed to line up with the

---
 rtl/vga_sync_gen.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// ============================================================================
// Module      : vga_sync_gen
// Description : Raster timing source for an 800x480 panel/DAC path.
//               Free-running horizontal/vertical pixel counters are exported
//               undelayed (vga_h / vga_v / frame_start) so a downstream frame
//               store can fetch pixels. hsync / vsync / de are decoded from the
//               same counters and pushed through a PIPE_DELAY-deep register
//               line so they line up with the registered pixel that the frame
//               store returns.
// Optional    : VGA_SYNC_FRAME_COUNT_EN - when defined, frame_count counts
//               completed frames (16-bit, wrapping). When undefined,
//               frame_count is tied to zero and no counter is built.
// Ports       :
//   clk          in   1   pixel clock
//   reset        in   1   synchronous, active-high reset
//   vga_h        out  11  horizontal count 0..H_TOTAL-1 (undelayed)
//   vga_v        out  11  vertical count 0..V_TOTAL-1 (undelayed)
//   frame_start  out  1   high while vga_h==0 && vga_v==0 (undelayed)
//   hsync        out  1   horizontal sync, HS_POL active, PIPE_DELAY late
//   vsync        out  1   vertical sync, VS_POL active, PIPE_DELAY late
//   de           out  1   display enable, PIPE_DELAY late
//   frame_count  out  16  completed-frame counter (optional, else 0)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_gen #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 13,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 29,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int PIPE_DELAY = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] vga_h,
  output logic [10:0] vga_v,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [15:0] frame_count
);

  // --------------------------------------------------------------------------
  // Timing constants (11-bit so every compare is a plain unsigned compare)
  // --------------------------------------------------------------------------
  localparam int c_H_TOTAL_I = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL_I = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] c_H_LAST   = 11'(c_H_TOTAL_I - 1);
  localparam logic [10:0] c_V_LAST   = 11'(c_V_TOTAL_I - 1);
  localparam logic [10:0] c_H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] c_V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] c_HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] c_VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] c_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Delay-line word is {hsync level, vsync level, de}; idle is sync inactive.
  localparam logic [2:0]  c_DL_IDLE  = {~HS_POL, ~VS_POL, 1'b0};

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if ((PIPE_DELAY < 1) || (PIPE_DELAY > 4)) begin : g_chk_pipe_delay
    $error("vga_sync_gen: PIPE_DELAY must be in 1..4");
  end

  if ((c_H_TOTAL_I >= 2048) || (c_V_TOTAL_I >= 2048)) begin : g_chk_totals
    $error("vga_sync_gen: H/V totals must stay below 2048");
  end

  // --------------------------------------------------------------------------
  // Pixel / line counters
  // --------------------------------------------------------------------------
  logic [10:0] r_h;
  logic [10:0] r_v;
  logic        w_h_last;
  logic        w_v_last;

  assign w_h_last = (r_h == c_H_LAST);
  assign w_v_last = (r_v == c_V_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h <= 11'd0;
      r_v <= 11'd0;
    end else if (w_h_last) begin
      // End of line: h wraps and v advances on the same edge.
      r_h <= 11'd0;
      r_v <= w_v_last ? 11'd0 : (r_v + 11'd1);
    end else begin
      r_h <= r_h + 11'd1;
    end
  end

  assign vga_h       = r_h;
  assign vga_v       = r_v;
  // Decoded straight from the counters, so it is also high throughout reset.
  assign frame_start = (r_h == 11'd0) && (r_v == 11'd0);

  // --------------------------------------------------------------------------
  // Raw decode of the current counter values
  // --------------------------------------------------------------------------
  logic       w_hs_raw;
  logic       w_vs_raw;
  logic       w_de_raw;
  logic [2:0] w_dl_in;

  assign w_hs_raw = (r_h >= c_HS_BEG) && (r_h < c_HS_END);
  assign w_vs_raw = (r_v >= c_VS_BEG) && (r_v < c_VS_END);
  assign w_de_raw = (r_h < c_H_ACT) && (r_v < c_V_ACT);

  // Polarity is applied before the delay line so the outputs are pure flops.
  assign w_dl_in  = {(w_hs_raw ? HS_POL : ~HS_POL),
                     (w_vs_raw ? VS_POL : ~VS_POL),
                     w_de_raw};

  // --------------------------------------------------------------------------
  // Alignment delay line: stage k holds the decode from k+1 clocks ago
  // --------------------------------------------------------------------------
  logic [2:0] r_dl [PIPE_DELAY];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < PIPE_DELAY; k++) begin
        r_dl[k] <= c_DL_IDLE;
      end
    end else begin
      r_dl[0] <= w_dl_in;
      for (int k = 1; k < PIPE_DELAY; k++) begin
        r_dl[k] <= r_dl[k-1];
      end
    end
  end

  assign hsync = r_dl[PIPE_DELAY-1][2];
  assign vsync = r_dl[PIPE_DELAY-1][1];
  assign de    = r_dl[PIPE_DELAY-1][0];

  // --------------------------------------------------------------------------
  // Optional completed-frame counter
  // --------------------------------------------------------------------------
`ifdef VGA_SYNC_FRAME_COUNT_EN
  logic [15:0] r_frame_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_count <= 16'h0000;
    end else if (w_h_last && w_v_last) begin
      // Counts on the edge where both counters return to 0; wraps at 0xFFFF.
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign frame_count = r_frame_count;
`else
  assign frame_count = 16'h0000;
`endif

endmodule

`default_nettype wire
